// File: rtl/stopwatch_pkg.sv
// Shared state encoding, direction constants and default rates for the
// stopwatch control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEFAULT_CLK_HZ          = 100_000_000;
  localparam int DEFAULT_TICK_HZ         = 100;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/stopwatch_control_if.sv
// Button/switch inputs and counter-chain control outputs of the stopwatch
// control stage; master drives the buttons, slave is the control block.
interface stopwatch_control_if;

  logic btn_start_stop;
  logic btn_clear;
  logic sw_dir;
  logic chain_at_limit;
  logic tick;
  logic up_down;
  logic clear;
  logic running;
  logic done;

  modport master (
    output btn_start_stop,
    output btn_clear,
    output sw_dir,
    output chain_at_limit,
    input  tick,
    input  up_down,
    input  clear,
    input  running,
    input  done
  );

  modport slave (
    input  btn_start_stop,
    input  btn_clear,
    input  sw_dir,
    input  chain_at_limit,
    output tick,
    output up_down,
    output clear,
    output running,
    output done
  );

endinterface

// File: rtl/stopwatch_control_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a
// registered one-cycle pulse on the accepted rising edge.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1) begin : gCycleCheck
    $error("debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0]    sync_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] stableCnt_q;
  logic [CW-1:0] stableCnt_d;
  logic          press_q;
  logic          press_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b00;
      level_q     <= 1'b0;
      stableCnt_q <= '0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      level_q     <= level_d;
      stableCnt_q <= stableCnt_d;
      press_q     <= press_d;
    end
  end

  // Any sample equal to the accepted level restarts the stability run.
  always_comb begin
    level_d     = level_q;
    stableCnt_d = '0;
    press_d     = 1'b0;
    if (sync_q[1] != level_q) begin
      if (stableCnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        stableCnt_d = stableCnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: debounced buttons, run/pause/done FSM, tick prescaler
// and direction latch feeding the BCD digit-counter chain.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int TICK_HZ         = DEFAULT_TICK_HZ,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic                clk,
  input logic                rst,
  stopwatch_control_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : gDivCheck
    $error("stopwatch_control: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic          startPress;
  logic          clearPress;
  logic [1:0]    dirSync_q;
  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] prescaler_q;
  logic [PW-1:0] prescaler_d;
  logic          tick_q;
  logic          tick_d;
  logic          clear_q;
  logic          clear_d;
  logic          upDown_q;
  logic          upDown_d;
  logic          running_q;
  logic          running_d;
  logic          done_q;
  logic          done_d;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStartStop (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.btn_start_stop),
    .press_o (startPress)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uClear (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.btn_clear),
    .press_o (clearPress)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirSync_q   <= 2'b00;
      state_q     <= IDLE;
      prescaler_q <= '0;
      tick_q      <= 1'b0;
      clear_q     <= 1'b0;
      upDown_q    <= DIR_UP;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dirSync_q   <= {dirSync_q[0], bus.sw_dir};
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      tick_q      <= tick_d;
      clear_q     <= clear_d;
      upDown_q    <= upDown_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  // Clear wins over start/stop; in down mode a wrap at the chain limit
  // becomes the transition to DONE instead of a tick.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    tick_d      = 1'b0;
    clear_d     = 1'b0;
    upDown_d    = upDown_q;
    if (state_q == IDLE) begin
      upDown_d = dirSync_q[1];
    end
    if (clearPress) begin
      clear_d     = 1'b1;
      state_d     = IDLE;
      prescaler_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startPress) begin
            state_d     = RUN;
            prescaler_d = '0;
          end
        end
        RUN: begin
          if (startPress) begin
            state_d = PAUSE;
          end else if (prescaler_q == PW'(DIV - 1)) begin
            prescaler_d = '0;
            if ((upDown_q == DIR_DOWN) && bus.chain_at_limit) begin
              state_d = DONE;
            end else begin
              tick_d = 1'b1;
            end
          end else begin
            prescaler_d = prescaler_q + 1'b1;
          end
        end
        PAUSE: begin
          if (startPress) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  assign bus.tick    = tick_q;
  assign bus.clear   = clear_q;
  assign bus.up_down = upDown_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: doc/stopwatch_control.md
# stopwatch_control

Control stage that drives the BCD digit-counter chain of the stopwatch. It debounces the start/stop and clear buttons and runs a run/pause/done state machine. It generates the single-cycle count `tick` fed to the first digit counter's `enable`, plus the shared `up_down` direction. In count-down mode it consumes the chain's terminal indication and halts at zero.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 100, count rate (one tick = 1/100 s).
- `DEBOUNCE_CYCLES`, 1_000_000, cycles a synchronized button level must be stable before it is accepted.
- Derived `DIV = CLK_HZ/TICK_HZ`. Must be ≥ 2 (elaboration error otherwise). Prescaler width is `$clog2(DIV)`.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1. One clock; reset is asynchronous and active-low (asserted at 0).
- `btn_start_stop`, in, 1, raw asynchronous button.
- `btn_clear`, in, 1, raw asynchronous button.
- `sw_dir`, in, 1, raw switch: 0 = count up, 1 = count down.
- `chain_at_limit`, in, 1. From the counter chain: all digits are at their terminal value for the current direction (all zero when counting down).
- `tick`, out, 1, one-cycle enable pulse to the least-significant digit counter.
- `up_down`, out, 1, direction to all digit counters.
- `clear`, out, 1, one-cycle synchronous clear pulse to the counter chain.
- `running`, out, 1, high in RUN.
- `done`, out, 1, high in DONE.

## Operation
- Buttons:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level updates after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
  - A press event is a one-cycle pulse on the debounced rising edge.
- `sw_dir`: 2-flop synchronized; latched into `up_down` only while in IDLE, ignored otherwise.
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
  - IDLE: start_stop press → RUN, prescaler = 0.
  - RUN:
    - Prescaler counts 0..DIV-1 and wraps.
    - `tick` = 1 in the cycle after prescaler == DIV-1.
    - start_stop press → PAUSE; prescaler holds its value.
  - PAUSE: start_stop press → RUN, prescaler resumes from its held value (no lost partial period).
  - DONE: `tick` = 0; start_stop ignored.
- Terminal handling:
  - Down mode: when a tick would issue and `chain_at_limit` = 1, suppress the tick and go to DONE.
  - Up mode: `chain_at_limit` is ignored and the chain wraps.
- Clear press in any state:
  - `clear` pulses for 1 cycle, next state is IDLE, prescaler = 0.
  - Clear has priority over a simultaneous start_stop press.
- Reset mid-run: all state drops immediately to reset values; no tick or clear is emitted on exit.

## Timing
- Reset values: `tick` = 0, `clear` = 0, `up_down` = 0, `running` = 0, `done` = 0, prescaler = 0, debounced levels = 0.
- All outputs are registered.
- Button latency: raw edge → press event ≤ 2 + `DEBOUNCE_CYCLES` + 1 cycles; state change on the following edge.
- First tick: DIV cycles after the cycle RUN is entered. Steady state: exactly one tick every DIV cycles, never two adjacent.
- `running` / `done` change in the same cycle as the state register.
- `clear` is asserted the cycle after the clear press event.
- `chain_at_limit` is sampled combinationally in the prescaler-wrap cycle; the chain must settle within one clock.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the direction constants DIR_UP = 0, DIR_DOWN = 1;
  - the default `CLK_HZ` / `TICK_HZ`.
- Sub-module `debounce` (synchronizer + stability counter + rising-edge pulse), parameter `DEBOUNCE_CYCLES`. Instantiated twice.
- Top contains the FSM, the prescaler and direction latch.

## Test plan
Bench parameters: CLK_HZ = 10, TICK_HZ = 1 (DIV = 10), DEBOUNCE_CYCLES = 4.
- Bounce: toggle `btn_start_stop` every 2 cycles for 20 cycles, then hold high → exactly one press event; RUN; first `tick` 10 cycles after entering RUN; then period 10.
- Pause/resume: press start_stop 4 cycles after a tick, then press again → PAUSE holds prescaler at 4; after resume the next tick arrives 6 cycles later.
- Down to zero: `sw_dir` = 1 in IDLE; start; force `chain_at_limit` = 1 → no tick; `done` = 1, `running` = 0; start_stop then ignored.
- Clear priority: start_stop and clear press events in the same cycle during RUN → one `clear` pulse, IDLE, `tick` stays 0.
- Direction lock: toggle `sw_dir` during RUN → `up_down` unchanged; after clear it follows the switch.
- Async reset while `tick` = 1 → all outputs 0 immediately; after release, IDLE with no spurious pulses.
